// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter / instruction sequencing unit.
// Steps the PC in two modes: free-run, at one instruction per TICK_DIV clocks,
// and single-step from a push button. It issues a one-cycle commit strobe
// that qualifies register-file and data-memory writes. It also handles
// exception vectoring, with EPC capture and return, and loading the PC
// from the switches.
//
// Ports:
//   SEQ_clk, SEQ_rst           clock, async active-high reset
//   SEQ_run                    1 = free-run, 0 = single-step
//   SEQ_step, SEQ_load         raw async button/switch (synchronised inside)
//   SEQ_load_val               PC value applied on a load event
//   SEQ_branch/SEQ_br_target   taken branch and its target
//   SEQ_jump/SEQ_jmp_target    jump and its target
//   SEQ_exc                    exception flag, sampled on commit cycles only
//   SEQ_eret                   return-from-exception
//   PC_current                 current PC (drives IMEM)
//   SEQ_commit                 1-cycle retire strobe
//   SEQ_wr_en                  write enable for REG/DMEM (combinational)
//   EPC, EPC_valid             exception PC and its valid flag
//   SEQ_state                  00 HALT, 01 RUN, 10 EXC
//   SEQ_retired                retired-write counter (only with SEQ_TRACE_EN)
//
// Build option: define SEQ_TRACE_EN to add the SEQ_retired counter port.
module pc_sequencer #(
  parameter int unsigned     PC_W       = 8,
  parameter logic [PC_W-1:0] RESET_PC   = '0,
  parameter logic [PC_W-1:0] EXC_VECTOR = '1,
  parameter int unsigned     TICK_DIV   = 50_000_000
) (
  input  logic            SEQ_clk,
  input  logic            SEQ_rst,
  input  logic            SEQ_run,
  input  logic            SEQ_step,
  input  logic            SEQ_load,
  input  logic [PC_W-1:0] SEQ_load_val,
  input  logic            SEQ_branch,
  input  logic [PC_W-1:0] SEQ_br_target,
  input  logic            SEQ_jump,
  input  logic [PC_W-1:0] SEQ_jmp_target,
  input  logic            SEQ_exc,
  input  logic            SEQ_eret,
  output logic [PC_W-1:0] PC_current,
  output logic            SEQ_commit,
  output logic            SEQ_wr_en,
  output logic [PC_W-1:0] EPC,
  output logic            EPC_valid,
  output logic [1:0]      SEQ_state
`ifdef SEQ_TRACE_EN
  ,
  output logic [31:0]     SEQ_retired
`endif
);

  localparam int unsigned CNT_W    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned TICK_MAX = TICK_DIV - 1;

  typedef enum logic [1:0] {
    ST_HALT = 2'b00,
    ST_RUN  = 2'b01,
    ST_EXC  = 2'b10
  } state_e;

  state_e          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            commit_q, commit_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] epc_q, epc_d;
  logic            epc_valid_q, epc_valid_d;

  logic [1:0]      step_sync_q, load_sync_q;
  logic            step_prev_q, load_prev_q;
  logic            step_ev_q, load_ev_q;

  // Next-state, next-PC and commit generation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    commit_d    = 1'b0;
    pc_d        = pc_q;
    epc_d       = epc_q;
    epc_valid_d = epc_valid_q;

    unique case (state_q)
      ST_HALT: begin
        commit_d = step_ev_q;
        if (SEQ_run) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        // The commit is issued on the cycle after the counter wraps.
        if (cnt_q == CNT_W'(TICK_MAX)) begin
          cnt_d    = '0;
          commit_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (!SEQ_run) begin
          state_d = ST_HALT;
          cnt_d   = '0;
        end
      end
      ST_EXC: begin
        cnt_d = '0;
        if (step_ev_q) state_d = ST_HALT;
      end
      default: state_d = ST_HALT;
    endcase

    // Retire the current instruction; priority is exc > eret > jump > branch > +1.
    if (commit_q) begin
      if (SEQ_exc) begin
        epc_d       = pc_q;
        epc_valid_d = 1'b1;
        pc_d        = EXC_VECTOR;
        state_d     = ST_EXC;
        cnt_d       = '0;
        commit_d    = 1'b0;
      end else if (SEQ_eret && epc_valid_q) begin
        pc_d        = epc_q + PC_W'(1);
        epc_valid_d = 1'b0;
      end else if (SEQ_jump) begin
        pc_d = SEQ_jmp_target;
      end else if (SEQ_branch) begin
        pc_d = SEQ_br_target;
      end else begin
        pc_d = pc_q + PC_W'(1);
      end
    end

    // A load overrides everything, including a coincident commit.
    if (load_ev_q) begin
      pc_d        = SEQ_load_val;
      epc_valid_d = 1'b0;
      state_d     = ST_HALT;
      cnt_d       = '0;
      commit_d    = 1'b0;
    end
  end

  // State, PC and synchroniser registers.
  always_ff @(posedge SEQ_clk or posedge SEQ_rst) begin
    if (SEQ_rst) begin
      state_q     <= ST_HALT;
      cnt_q       <= '0;
      commit_q    <= 1'b0;
      pc_q        <= RESET_PC;
      epc_q       <= '0;
      epc_valid_q <= 1'b0;
      step_sync_q <= '0;
      load_sync_q <= '0;
      step_prev_q <= 1'b0;
      load_prev_q <= 1'b0;
      step_ev_q   <= 1'b0;
      load_ev_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      commit_q    <= commit_d;
      pc_q        <= pc_d;
      epc_q       <= epc_d;
      epc_valid_q <= epc_valid_d;
      // Two-flop synchroniser, then a registered rising-edge pulse.
      step_sync_q <= {step_sync_q[0], SEQ_step};
      load_sync_q <= {load_sync_q[0], SEQ_load};
      step_prev_q <= step_sync_q[1];
      load_prev_q <= load_sync_q[1];
      step_ev_q   <= step_sync_q[1] & ~step_prev_q;
      load_ev_q   <= load_sync_q[1] & ~load_prev_q;
    end
  end

  assign PC_current = pc_q;
  assign SEQ_commit = commit_q;
  assign SEQ_wr_en  = commit_q & ~SEQ_exc & ~load_ev_q;
  assign EPC        = epc_q;
  assign EPC_valid  = epc_valid_q;
  assign SEQ_state  = state_q;

`ifdef SEQ_TRACE_EN
  logic [31:0] retired_q;

  // Count instructions that actually wrote back.
  always_ff @(posedge SEQ_clk or posedge SEQ_rst) begin
    if (SEQ_rst) retired_q <= '0;
    else if (SEQ_wr_en) retired_q <= retired_q + 32'd1;
  end

  assign SEQ_retired = retired_q;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer (PC_W=8, TICK_DIV=4, EXC_VECTOR=F0).
// Expected retire results are queued when a commit is provoked and checked
// when the DUT strobes SEQ_commit.
module tb_pc_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       run, step, load, branch, jump, exc, eret;
  logic [7:0] load_val, br_target, jmp_target;
  logic [7:0] pc, epc;
  logic       commit, wr_en, epc_valid;
  logic [1:0] state;
`ifdef SEQ_TRACE_EN
  logic [31:0] retired;
`endif

  pc_sequencer #(
    .PC_W(8), .RESET_PC(8'h00), .EXC_VECTOR(8'hF0), .TICK_DIV(4)
  ) dut (
    .SEQ_clk(clk), .SEQ_rst(rst), .SEQ_run(run), .SEQ_step(step),
    .SEQ_load(load), .SEQ_load_val(load_val),
    .SEQ_branch(branch), .SEQ_br_target(br_target),
    .SEQ_jump(jump), .SEQ_jmp_target(jmp_target),
    .SEQ_exc(exc), .SEQ_eret(eret),
    .PC_current(pc), .SEQ_commit(commit), .SEQ_wr_en(wr_en),
    .EPC(epc), .EPC_valid(epc_valid), .SEQ_state(state)
`ifdef SEQ_TRACE_EN
    , .SEQ_retired(retired)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] pc;
    logic       wr;
  } exp_t;

  exp_t exp_q[$];
  exp_t pend;
  logic pc_pending = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   last_commit = -1;
  logic gap_chk = 1'b0;
  int   exp_retired = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance n cycles, retiring queued expectations as commits appear.
  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cyc++;
      if (pc_pending) begin
        check("pc_after_commit", pc, pend.pc);
        check("commit_width", commit, 1'b0);
        pc_pending = 1'b0;
      end
      if (commit) begin
        if (exp_q.size() == 0) begin
          check("commit_unexpected", commit, 1'b0);
        end else begin
          pend = exp_q.pop_front();
          check("wr_en", wr_en, pend.wr);
          if (pend.wr) exp_retired++;
          pc_pending = 1'b1;
          if (gap_chk && last_commit >= 0) check("commit_gap", cyc - last_commit, 4);
          last_commit = cyc;
        end
      end
    end
  endtask

  task automatic step_pulse();
    step = 1'b1;
    run_cycles(2);
    step = 1'b0;
  endtask

  // One single-step commit; the expectation is queued by the caller.
  task automatic step_commit();
    step_pulse();
    run_cycles(6);
    check("commit_seen", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic load_pc(input logic [7:0] v);
    load_val = v;
    load = 1'b1;
    run_cycles(2);
    load = 1'b0;
    run_cycles(4);
    check("load_pc", pc, v);
  endtask

  initial begin
    rst = 1'b1;
    {run, step, load, branch, jump, exc, eret} = '0;
    load_val = '0; br_target = '0; jmp_target = '0;
    repeat (3) @(negedge clk);
    check("rst_pc", pc, 8'h00);
    check("rst_commit", commit, 1'b0);
    check("rst_epc", epc, 8'h00);
    check("rst_epc_valid", epc_valid, 1'b0);
    check("rst_state", state, 2'b00);
    rst = 1'b0;
    run_cycles(2);

    // Single-step: three commits, PC 00 -> 03.
    for (int k = 1; k <= 3; k++) begin
      exp_q.push_back('{pc: 8'(k), wr: 1'b1});
      step_commit();
    end
    check("step_pc", pc, 8'h03);
    check("step_epc_valid", epc_valid, 1'b0);

    // Free-run from FE: five commits, PC wraps through 00.
    load_pc(8'hFE);
    check("load_state", state, 2'b00);
    for (int k = 0; k < 5; k++) exp_q.push_back('{pc: 8'(8'hFF + k), wr: 1'b1});
    gap_chk = 1'b1;
    last_commit = -1;
    run = 1'b1;
    run_cycles(20);
    run = 1'b0;
    run_cycles(6);
    gap_chk = 1'b0;
    check("run_commits", exp_q.size(), 0);
    exp_q.delete();
    check("run_pc", pc, 8'h03);
    check("run_to_halt", state, 2'b00);

    // Load event coincides with a jump commit: load wins, no write.
    step = 1'b1;
    @(negedge clk);
    load_val = 8'h40; load = 1'b1; jump = 1'b1; jmp_target = 8'h77;
    @(negedge clk);
    step = 1'b0;
    repeat (2) @(negedge clk);
    check("coinc_commit", commit, 1'b1);
    check("coinc_wr_en", wr_en, 1'b0);
    @(negedge clk);
    check("coinc_pc", pc, 8'h40);
    check("coinc_state", state, 2'b00);
    load = 1'b0; jump = 1'b0;
    run_cycles(4);

    // Exception at PC 12, then step back to HALT and eret to 13.
    load_pc(8'h12);
    exc = 1'b1;
    exp_q.push_back('{pc: 8'hF0, wr: 1'b0});
    step_commit();
    exc = 1'b0;
    check("exc_epc", epc, 8'h12);
    check("exc_epc_valid", epc_valid, 1'b1);
    check("exc_state", state, 2'b10);
    run = 1'b1;
    run_cycles(12);
    run = 1'b0;
    check("exc_run_pc", pc, 8'hF0);
    check("exc_run_state", state, 2'b10);
    step_pulse();
    run_cycles(4);
    check("exc_step_halt", state, 2'b00);
    eret = 1'b1;
    exp_q.push_back('{pc: 8'h13, wr: 1'b1});
    step_commit();
    eret = 1'b0;
    check("eret_epc_valid", epc_valid, 1'b0);

    // Jump beats branch; eret with no valid EPC behaves as PC+1.
    branch = 1'b1; br_target = 8'h2A; jump = 1'b1; jmp_target = 8'h55;
    exp_q.push_back('{pc: 8'h55, wr: 1'b1});
    step_commit();
    branch = 1'b0; jump = 1'b0; eret = 1'b1;
    exp_q.push_back('{pc: 8'h56, wr: 1'b1});
    step_commit();
    eret = 1'b0;

    // EPC at FF returns to 00.
    load_pc(8'hFF);
    exc = 1'b1;
    exp_q.push_back('{pc: 8'hF0, wr: 1'b0});
    step_commit();
    exc = 1'b0;
    check("wrap_epc", epc, 8'hFF);
    step_pulse();
    run_cycles(4);
    eret = 1'b1;
    exp_q.push_back('{pc: 8'h00, wr: 1'b1});
    step_commit();
    eret = 1'b0;
    check("wrap_epc_valid", epc_valid, 1'b0);

`ifdef SEQ_TRACE_EN
    check("retired_count", retired, 32'(exp_retired));
`endif

    // Async reset during a pending commit drops it.
    load_pc(8'h33);
    step_pulse();
    repeat (2) @(negedge clk);
    check("mid_commit_high", commit, 1'b1);
    rst = 1'b1;
    #1;
    check("mid_rst_commit", commit, 1'b0);
    check("mid_rst_pc", pc, 8'h00);
    check("mid_rst_state", state, 2'b00);
`ifdef SEQ_TRACE_EN
    check("mid_rst_retired", retired, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    run_cycles(4);
    check("post_rst_pc", pc, 8'h00);
    check("queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
